// File: rtl/led_reg_responder.sv
// Register-mapped LED pattern engine: decodes byte writes from the sequencer bus,
// steps a 16-bit LED bank on a programmable delay and offers a registered read-back port.
module led_reg_responder #(
  parameter int          LED_W         = 16,
  parameter logic [31:0] DEFAULT_DELAY = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       data_address,
  input  logic [7:0]       write_data,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         pos_q, pos_d;
  logic [2:0]         mode_q, mode_d;
  logic [7:0]         steps_q, steps_d;
  logic [31:0]        delay_q, delay_d;
  logic [7:0]         stg04_q, stg04_d, stg05_q, stg05_d, stg06_q, stg06_d;
  logic               done_q, done_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [7:0]         step_left_q, step_left_d;
  logic               dir_right_q, dir_right_d;
  logic               blink_ph_q, blink_ph_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               tick_q, tick_d;
  logic               running_q, running_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic [LED_W-1:0]   pos_hot, wr_hot, step_led;
  logic               step_dir, step_ph, step_now;
  logic [31:0]        reload_cur, commit_val, commit_reload;
  logic [7:0]         rd_mux;

  assign pos_hot       = {{(LED_W-1){1'b0}}, 1'b1} << pos_q;
  assign wr_hot        = {{(LED_W-1){1'b0}}, 1'b1} << write_data[3:0];
  assign reload_cur    = (delay_q == 32'd0) ? 32'd1 : delay_q;
  assign commit_val    = {stg04_q, stg05_q, stg06_q, write_data};
  assign commit_reload = (commit_val == 32'd0) ? 32'd1 : commit_val;
  // A zero delay means "step every cycle", so it bypasses the countdown.
  assign step_now      = (state_q == ST_RUN) && ((cnt_q == 32'd1) || (delay_q == 32'd0));

  always_comb begin
    step_led = led_q;
    step_dir = dir_right_q;
    step_ph  = blink_ph_q;
    case (mode_q)
      3'd1: step_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
      3'd2: step_led = {led_q[0], led_q[LED_W-1:1]};
      3'd3: begin
        if (led_q[LED_W-1]) begin
          step_dir = 1'b1;
          step_led = led_q >> 1;
        end else if (led_q[0]) begin
          step_dir = 1'b0;
          step_led = led_q << 1;
        end else begin
          step_led = dir_right_q ? (led_q >> 1) : (led_q << 1);
        end
      end
      3'd4: begin
        step_ph  = ~blink_ph_q;
        step_led = blink_ph_q ? pos_hot : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (data_address)
      8'h01:   rd_mux = {4'b0, pos_q};
      8'h02:   rd_mux = {5'b0, mode_q};
      8'h03:   rd_mux = steps_q;
      8'h04:   rd_mux = delay_q[31:24];
      8'h05:   rd_mux = delay_q[23:16];
      8'h06:   rd_mux = delay_q[15:8];
      8'h07:   rd_mux = delay_q[7:0];
      8'h09:   rd_mux = {6'b0, done_q, running_q};
      default: rd_mux = 8'h00;
    endcase
  end

  // Read port: rd_en in cycle N yields rd_valid=1 with rd_data in N+1, no backpressure;
  // the mux looks at current register values, so a same-cycle write is not yet visible.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    mode_d      = mode_q;
    steps_d     = steps_q;
    delay_d     = delay_q;
    stg04_d     = stg04_q;
    stg05_d     = stg05_q;
    stg06_d     = stg06_q;
    done_d      = done_q;
    cnt_d       = cnt_q;
    step_left_d = step_left_q;
    dir_right_d = dir_right_q;
    blink_ph_d  = blink_ph_q;
    led_d       = led_q;
    tick_d      = 1'b0;
    rd_valid_d  = rd_en;
    rd_data_d   = rd_en ? rd_mux : rd_data_q;

    if (state_q == ST_RUN) begin
      if (step_now) begin
        tick_d      = 1'b1;
        led_d       = step_led;
        dir_right_d = step_dir;
        blink_ph_d  = step_ph;
        cnt_d       = reload_cur;
        if ((steps_q != 8'd0) && (step_left_q != 8'd0)) begin
          step_left_d = step_left_q - 8'd1;
          if (step_left_q == 8'd1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end

    // Register writes land after the step so a POS write overrides the stepped LED value.
    if (wr_en) begin
      case (data_address)
        8'h01: begin
          pos_d      = write_data[3:0];
          led_d      = wr_hot;
          blink_ph_d = 1'b0;
          cnt_d      = reload_cur;
        end
        8'h02: mode_d  = write_data[2:0];
        8'h03: steps_d = write_data;
        8'h04: stg04_d = write_data;
        8'h05: stg05_d = write_data;
        8'h06: stg06_d = write_data;
        8'h07: begin
          delay_d = commit_val;
          cnt_d   = commit_reload;
        end
        8'h08: begin
          if (write_data[1]) begin
            led_d      = pos_hot;
            blink_ph_d = 1'b0;
            done_d     = 1'b0;
            state_d    = ST_IDLE;
          end else if (write_data[0]) begin
            state_d     = ST_RUN;
            step_left_d = steps_q;
            cnt_d       = reload_cur;
          end else if (state_q == ST_RUN) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= 4'd0;
      mode_q      <= 3'd0;
      steps_q     <= 8'd0;
      delay_q     <= DEFAULT_DELAY;
      stg04_q     <= 8'd0;
      stg05_q     <= 8'd0;
      stg06_q     <= 8'd0;
      done_q      <= 1'b0;
      cnt_q       <= DEFAULT_DELAY;
      step_left_q <= 8'd0;
      dir_right_q <= 1'b0;
      blink_ph_q  <= 1'b0;
      led_q       <= {{(LED_W-1){1'b0}}, 1'b1};
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      mode_q      <= mode_d;
      steps_q     <= steps_d;
      delay_q     <= delay_d;
      stg04_q     <= stg04_d;
      stg05_q     <= stg05_d;
      stg06_q     <= stg06_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      step_left_q <= step_left_d;
      dir_right_q <= dir_right_d;
      blink_ph_q  <= blink_ph_d;
      led_q       <= led_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign led      = led_q;
  assign tick     = tick_q;
  assign running  = running_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/led_reg_responder.md
Name: led_reg_responder

Overview:
- Register-mapped responder at the far end of the 8-bit write bus driven by the ROM sequencer (wr_en / data_address / write_data).
- Decodes register writes and runs a timed LED pattern engine on a 16-bit LED bank.
- Provides a registered read-back port so the sequencer's "verify" opcodes can check what was written.

Parameters:
LED_W, 16, LED bank width (pattern logic is specified for 16).
DEFAULT_DELAY, 32'd4, step delay in clk cycles after reset.

Ports:
clk  in  1  clock
rst  in  1  reset
wr_en  in  1  write strobe; one write per cycle when high
data_address  in  8  register address for write and read
write_data  in  8  write data
rd_en  in  1  read strobe
rd_data  out  8  registered read data
rd_valid  out  1  high one cycle after rd_en
led  out  16  LED drive
tick  out  1  one-cycle pulse on each pattern step
running  out  1  high while the engine is in RUN

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. Reset sets:
  - Outputs: led=16'h0001, rd_data=0, rd_valid=0, tick=0, running=0.
  - Registers: POS=0, MODE=0, STEPS=0, DELAY=DEFAULT_DELAY, staging=0, done=0, delay counter=DEFAULT_DELAY, dir=left, state=IDLE.
- Register map (writes to other addresses are ignored; reads of other addresses return 8'h00):
  - 0x01 POS: position = write_data[3:0]. Loads led=1<<pos, clears blink phase, reloads the delay counter.
  - 0x02 MODE: write_data[2:0]. 0=static, 1=rotate-left, 2=rotate-right, 3=bounce, 4=blink. Codes 5-7 behave as static. Takes effect at the next step.
  - 0x03 STEPS: number of steps to run; 0 = run forever.
  - 0x04..0x07 DELAY bytes, MSB first (0x04 = bits 31:24).
    - 0x04..0x06 write staging bytes only.
    - A write to 0x07 commits {stg04,stg05,stg06,write_data} to DELAY atomically and reloads the counter.
    - Reads of 0x04..0x07 return the committed DELAY bytes.
  - 0x08 CTRL: bit0 run, bit1 clear.
    - clear: led=1<<POS, done=0, state=IDLE.
    - bit1 takes priority over bit0 when both are set.
  - 0x09 STATUS (read-only): {6'b0, done, running}.
- Read port:
  - rd_en in cycle N gives rd_data and rd_valid=1 in cycle N+1.
  - Without rd_en, rd_valid=0 and rd_data holds its last value.
  - Read and write to the same address in the same cycle: the read returns the pre-write value.
- State machine IDLE / RUN / DONE:
  - IDLE -> RUN: CTRL write with run=1. Loads step_left=STEPS and reloads the delay counter.
  - RUN: counter decrements each cycle. At counter==1, or when DELAY==0 (treated as 1, i.e. step every cycle):
    - pulse tick;
    - apply one step;
    - reload counter=max(DELAY,1);
    - if STEPS!=0, decrement step_left.
  - RUN -> DONE: when the step that makes step_left reach 0 completes. Sets done=1, running=0, and led holds.
  - RUN -> IDLE: CTRL write with run=0. led holds.
  - DONE -> RUN: CTRL write with run=1 restarts the run. DONE -> IDLE: clear.
- Step rules:
  - rotate-left: led={led[14:0],led[15]}.
  - rotate-right: led={led[0],led[15:1]}.
  - bounce: shift in dir. At led[15], dir becomes right and the next value is bit14. At led[0], dir becomes left.
  - blink: alternate between 16'h0000 and 1<<POS on each step.
  - static: no change, but tick still pulses.
- Simultaneous events:
  - A POS write in the same cycle as a step: the write wins (led=1<<pos), the step is discarded, and step_left is still decremented.
  - A DELAY commit during RUN reloads the counter immediately.
- Reset mid-run returns everything to reset values in the same cycle. The engine does not resume after reset is released.

Test Plan:
- Reset, then read 0x01 and 0x09 -> rd_data 0x00, 0x00 one cycle after each rd_en; led=0x0001.
- Write POS=5, MODE=1, DELAY=0,0,0,3, STEPS=4, CTRL=1 -> tick every 3 cycles; led 0x0040, 0x0080, 0x0100, 0x0200; then running=0 and STATUS=0x02.
- MODE=2, POS=0, DELAY=1, STEPS=2, run -> led 0x8000 then 0x4000 (wrap-around at bit 0).
- MODE=3, POS=14, DELAY=1, STEPS=4, run -> led 0x8000, 0x4000, 0x2000, 0x1000 (reversal at bit 15).
- Write 0x04..0x06 only (0x12, 0x34, 0x56), then read 0x04 -> DEFAULT_DELAY MSB 0x00; write 0x07=0x78, read 0x04..0x07 -> 0x12, 0x34, 0x56, 0x78.
- MODE=4, POS=3, DELAY=2, STEPS=0, run, assert rst after 5 ticks -> led alternates 0x0000/0x0008; after reset led=0x0001, running=0, DELAY=4.
